// File: rtl/seg_scan_if.sv
// Digit-pattern/mask inputs and anode/cathode pin outputs of the 7-segment scan driver.
// master = pattern/mask producer, slave = scan driver.
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 7
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [NUM_DIGITS*SEG_W-1:0] seg_data;
  logic                        blink_en;
  logic [NUM_DIGITS-1:0]       blink_mask;
  logic [NUM_DIGITS-1:0]       blank_mask;
  logic [SEG_W-1:0]            cathode;
  logic [NUM_DIGITS-1:0]       anode;
  logic [IDX_W-1:0]            digit_idx;
  logic                        frame_start;

  modport master (
    output seg_data, blink_en, blink_mask, blank_mask,
    input  cathode, anode, digit_idx, frame_start
  );

  modport slave (
    input  seg_data, blink_en, blink_mask, blank_mask,
    output cathode, anode, digit_idx, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with dead time between digits,
// per-digit blink/blank masks and an on-clk_sys scan/blink prescaler.
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 7,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEAD_CYC   = 2,
  parameter int unsigned BLINK_DIV  = 128
) (
  input  logic       clk_sys,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      cur_digit;
  logic [BLK_W-1:0]      blink_cnt;
  logic                  blink_phase;

  logic [NUM_DIGITS-1:0] anode_reg;
  logic [SEG_W-1:0]      cathode_reg;
  logic [IDX_W-1:0]      digit_idx_reg;
  logic                  frame_start_reg;

  logic                  slot_wrap_c;
  logic                  dead_c;
  logic                  hide_c;
  logic [SEG_W-1:0]      pattern_c;
  logic [NUM_DIGITS-1:0] onehot_c;

  assign slot_wrap_c = (slot_cnt == CNT_W'(SCAN_DIV - 1));
  assign dead_c      = (32'(slot_cnt) < DEAD_CYC);
  assign onehot_c    = ~(NUM_DIGITS'(1) << cur_digit);

  // blank_mask wins over blink; blink only hides during the dark phase
  assign hide_c = bus.blank_mask[cur_digit] ||
                  (bus.blink_en && bus.blink_mask[cur_digit] && !blink_phase);

  // live pattern for the digit owning the slot
  always_comb begin
    pattern_c = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == cur_digit) begin
        pattern_c = bus.seg_data[k*SEG_W +: SEG_W];
      end
    end
  end

  // scan position, blink timer and registered pin outputs
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      slot_cnt        <= '0;
      cur_digit       <= '0;
      blink_cnt       <= '0;
      blink_phase     <= 1'b1;
      anode_reg       <= '1;
      cathode_reg     <= '1;
      digit_idx_reg   <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap_c ? '0 : slot_cnt + CNT_W'(1);
      if (slot_wrap_c) begin
        cur_digit <= (cur_digit == IDX_W'(NUM_DIGITS - 1)) ? '0 : cur_digit + IDX_W'(1);
      end

      // leaving adjust mode rearms a full visible half-period
      if (!bus.blink_en) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (slot_wrap_c) begin
        if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end

      anode_reg       <= dead_c ? '1 : onehot_c;
      cathode_reg     <= (dead_c || hide_c) ? '1 : pattern_c;
      digit_idx_reg   <= cur_digit;
      frame_start_reg <= (slot_cnt == '0) && (cur_digit == '0);
    end
  end

  assign bus.anode       = anode_reg;
  assign bus.cathode     = cathode_reg;
  assign bus.digit_idx   = digit_idx_reg;
  assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: scan-position/blink-history model compared
// every cycle, plus hand-computed pin values at chosen scan positions.
module tb_seg_scan_driver;

  localparam int unsigned N = 4;
  localparam int unsigned W = 7;
  localparam int unsigned S = 8;
  localparam int unsigned D = 2;
  localparam int unsigned B = 2;
  localparam int unsigned FRAME = N * S;

  logic clk_sys = 1'b0;
  logic rst;

  always #5 clk_sys = ~clk_sys;

  seg_scan_if #(.NUM_DIGITS(N), .SEG_W(W)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS(N), .SEG_W(W), .SCAN_DIV(S), .DEAD_CYC(D), .BLINK_DIV(B)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: m_pos = scan position (cycles since reset release) the next edge
  // consumes; m_wraps = slot ends seen while blink_en stayed continuously high.
  bit                  m_valid = 1'b0;
  int                  m_pos   = 0;
  int                  m_wraps = 0;
  logic [N-1:0]        m_anode;
  logic [W-1:0]        m_cath;
  logic [$clog2(N)-1:0] m_idx;
  logic                m_fs;

  always @(posedge clk_sys) begin : model
    int slot;
    int dig;
    bit visible;
    if (rst) begin
      m_valid = 1'b1;
      m_pos   = 0;
      m_wraps = 0;
      m_anode = '1;
      m_cath  = '1;
      m_idx   = '0;
      m_fs    = 1'b0;
    end else begin
      slot    = m_pos % S;
      dig     = (m_pos / S) % N;
      visible = ((m_wraps / B) % 2) == 0;
      m_idx   = ($clog2(N))'(dig);
      m_fs    = (slot == 0) && (dig == 0);
      m_anode = '1;
      m_cath  = '1;
      if (slot >= D) begin
        m_anode[dig] = 1'b0;
        if (!(bus.blank_mask[dig] || (bus.blink_en && bus.blink_mask[dig] && !visible)))
          m_cath = bus.seg_data[dig*W +: W];
      end
      if (!bus.blink_en) m_wraps = 0;
      else if (slot == S - 1) m_wraps = m_wraps + 1;
      m_pos = m_pos + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h (pos %0d, t=%0t)", nm, got, exp, m_pos - 1, $time);
    end
  endtask

  // advance one cycle and compare every output against the model
  task automatic tick();
    @(negedge clk_sys);
    if (m_valid) begin
      chk("anode",       32'(bus.anode),       32'(m_anode));
      chk("cathode",     32'(bus.cathode),     32'(m_cath));
      chk("digit_idx",   32'(bus.digit_idx),   32'(m_idx));
      chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
      chk("anode_onehot", 32'($countones(~bus.anode) <= 1), 32'd1);
    end
  endtask

  // stop at the negedge where the next edge consumes frame position t
  task automatic wait_pos(input int t);
    for (int i = 0; i < 2 * FRAME && (m_pos % FRAME) != t; i++) tick();
    chk("wait_pos", 32'(m_pos % FRAME), 32'(t));
  endtask

  // stop at the negedge where the outputs show frame position t
  task automatic show(input int t);
    wait_pos((t + 1) % FRAME);
  endtask

  task automatic lit(input string nm, input logic [N-1:0] an, input logic [W-1:0] ca);
    chk({nm, "_anode"},   32'(bus.anode),   32'(an));
    chk({nm, "_cathode"}, 32'(bus.cathode), 32'(ca));
  endtask

  typedef struct {
    logic         en;
    logic [N-1:0] bmask;
    logic [N-1:0] blank;
  } mask_vec_t;

  mask_vec_t vecs [4];

  initial begin
    vecs[0] = '{1'b1, 4'b1111, 4'b0000};
    vecs[1] = '{1'b1, 4'b1010, 4'b0101};
    vecs[2] = '{1'b0, 4'b1111, 4'b1001};
    vecs[3] = '{1'b0, 4'b0000, 4'b0000};

    rst             = 1'b1;
    bus.seg_data    = {7'h08, 7'h04, 7'h02, 7'h01};
    bus.blink_en    = 1'b0;
    bus.blink_mask  = '0;
    bus.blank_mask  = '0;

    // reset state
    repeat (3) tick();
    lit("reset", 4'b1111, 7'h7F);
    chk("reset_idx", 32'(bus.digit_idx), 32'd0);
    chk("reset_fs",  32'(bus.frame_start), 32'd0);

    // plain scan after release
    rst = 1'b0;
    tick();
    lit("first_dead", 4'b1111, 7'h7F);
    chk("first_fs", 32'(bus.frame_start), 32'd1);
    repeat (2) tick();
    lit("dig0", 4'b1110, 7'h01);
    chk("dig0_fs", 32'(bus.frame_start), 32'd0);
    repeat (8) tick();
    lit("dig1", 4'b1101, 7'h02);
    chk("dig1_idx", 32'(bus.digit_idx), 32'd1);
    repeat (16) tick();
    lit("dig3", 4'b0111, 7'h08);
    repeat (6) tick();
    lit("frame2_dead", 4'b1111, 7'h7F);
    chk("frame2_fs", 32'(bus.frame_start), 32'd1);
    repeat (2) tick();
    lit("frame2_dig0", 4'b1110, 7'h01);

    // blink entered at the start of digit 2's slot
    wait_pos(16);
    bus.blink_en   = 1'b1;
    bus.blink_mask = 4'b0011;
    show(2);
    lit("blink_dark_dig0", 4'b1110, 7'h7F);
    show(10);
    lit("blink_dark_dig1", 4'b1101, 7'h7F);
    show(18);
    lit("blink_dig2_unmasked", 4'b1011, 7'h04);
    show(2);
    lit("blink_dark_dig0_b", 4'b1110, 7'h7F);

    // drop and re-enter adjust mode during the dark half
    bus.blink_en = 1'b0;
    tick();
    lit("blink_off", 4'b1110, 7'h01);
    bus.blink_en = 1'b1;
    show(10);
    lit("reentry_dig1", 4'b1101, 7'h02);
    show(2);
    lit("reentry_dig0", 4'b1110, 7'h01);
    bus.blink_en   = 1'b0;
    bus.blink_mask = '0;

    // blank priority
    bus.blank_mask = 4'b0100;
    show(20);
    lit("blank_dig2", 4'b1011, 7'h7F);
    show(28);
    lit("blank_dig3", 4'b0111, 7'h08);
    bus.blink_en   = 1'b1;
    bus.blink_mask = 4'b0100;
    repeat (FRAME) tick();
    bus.blink_en   = 1'b0;
    bus.blink_mask = '0;
    bus.blank_mask = '0;

    // live mid-slot data update on digit 1
    wait_pos(13);
    lit("live_before", 4'b1101, 7'h02);
    bus.seg_data[1*W +: W] = 7'h40;
    tick();
    lit("live_after", 4'b1101, 7'h40);

    // mask/blink combinations over whole frames
    for (int v = 0; v < 4; v++) begin
      bus.blink_en   = vecs[v].en;
      bus.blink_mask = vecs[v].bmask;
      bus.blank_mask = vecs[v].blank;
      repeat (2 * FRAME) tick();
    end

    // mid-slot reset in digit 2's active window
    wait_pos(20);
    rst = 1'b1;
    tick();
    lit("midreset", 4'b1111, 7'h7F);
    chk("midreset_idx", 32'(bus.digit_idx), 32'd0);
    rst = 1'b0;
    tick();
    lit("restart_dead", 4'b1111, 7'h7F);
    chk("restart_fs", 32'(bus.frame_start), 32'd1);
    repeat (2) tick();
    lit("restart_dig0", 4'b1110, 7'h01);
    repeat (FRAME) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
